// File: rtl/palt_nios_pio_pkg.sv
// Shared constants for the palt_nios PIO blocks (input and output GPIO).
// Holds the 4-word register window map and the edge-capture selections.
package palt_nios_pio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_ECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Avalon-MM write qualifier: selected and write strobe (active-low) asserted.
  function automatic logic is_write(input logic cs, input logic wr_n);
    return cs & ~wr_n;
  endfunction

endpackage

// File: rtl/palt_nios_pio_sync.sv
// Input synchroniser chain, delayed copy, post-reset warm-up and edge pulse.
// edge_c is a single-cycle pulse per bit, suppressed until the chain has refilled.
module palt_nios_pio_sync
  import palt_nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] edge_c
);

  localparam int unsigned WARM  = SYNC_STAGES + 1;
  localparam int unsigned CNT_W = $clog2(WARM + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]                  prev_q;
  logic [CNT_W-1:0]                  warm_cnt;
  logic [WIDTH-1:0]                  raw_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync_q = chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= sync_q;
    end
  end

  // Covers the chain refilling after reset so a level held through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt <= CNT_W'(WARM);
    end else if (warm_cnt != '0) begin
      warm_cnt <= warm_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    raw_edge = '0;
    case (EDGE_TYPE)
      EDGE_RISE: raw_edge = sync_q & ~prev_q;
      EDGE_FALL: raw_edge = ~sync_q & prev_q;
      default:   raw_edge = sync_q ^ prev_q;
    endcase
  end

  assign edge_c = (warm_cnt == '0) ? raw_edge : '0;

endmodule

// File: rtl/palt_nios_gpio_in.sv
// Avalon-MM input PIO: synchronised data, interrupt mask, sticky edge capture (W1C)
// and a level interrupt built from registered state only.
module palt_nios_gpio_in
  import palt_nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [DATA_W-1:0] readdata,
  output logic              irq
);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] edge_c;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] clr_bits;
  logic             wr;
  logic             mask_wr;
  logic             ecap_wr;
  logic             unused_wdata;

  palt_nios_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .sync_q  (sync_q),
    .edge_c  (edge_c)
  );

  assign wr           = is_write(chipselect, write_n);
  assign mask_wr      = wr && (address == ADDR_MASK);
  assign ecap_wr      = wr && (address == ADDR_ECAP);
  assign clr_bits     = ecap_wr ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^(writedata >> WIDTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (mask_wr) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // A new edge is OR-ed in after the clear, so a set in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~clr_bits) | edge_c;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = DATA_W'(sync_q);
      ADDR_RSVD: readdata = '0;
      ADDR_MASK: readdata = DATA_W'(irq_mask);
      ADDR_ECAP: readdata = DATA_W'(edge_cap);
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_palt_nios_gpio_in.sv
// Bench for palt_nios_gpio_in: three instances (rise/fall/any) share one bus and input,
// compared every cycle against a sample-history reference model.
module tb_palt_nios_gpio_in;
  import palt_nios_pio_pkg::*;

  localparam int W = 2;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_rise, rd_fall, rd_any;
  logic          irq_rise, irq_fall, irq_any;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  palt_nios_gpio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(EDGE_RISE)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_rise), .irq(irq_rise));
  palt_nios_gpio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(EDGE_FALL)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_fall), .irq(irq_fall));
  palt_nios_gpio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(EDGE_ANY)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_any), .irq(irq_any));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: input samples taken since the last reset (newest last, at most S+1 kept).
  logic [W-1:0] hist[$];
  logic [W-1:0] m_mask;
  logic [W-1:0] m_ecap[3];

  function automatic logic [W-1:0] m_data();
    if (hist.size() >= S) return hist[hist.size() - S];
    return '0;
  endfunction

  // Edges only exist between two genuine post-reset samples that have both left the chain.
  function automatic logic [W-1:0] m_edge(input int k);
    logic [W-1:0] cur, prv;
    if (hist.size() < S + 1) return '0;
    cur = hist[hist.size() - S];
    prv = hist[hist.size() - S - 1];
    case (k)
      0:       return cur & ~prv;
      1:       return ~cur & prv;
      default: return cur ^ prv;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_data());
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(m_ecap[k]);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clock();
    logic [W-1:0] pulse[3];
    logic         wr;
    if (reset) begin
      hist.delete();
      m_mask = '0;
      for (int k = 0; k < 3; k++) m_ecap[k] = '0;
    end else begin
      wr = chipselect && !write_n;
      for (int k = 0; k < 3; k++) pulse[k] = m_edge(k);
      for (int k = 0; k < 3; k++)
        m_ecap[k] = (m_ecap[k] & ~((wr && address == 2'd3) ? writedata[W-1:0] : '0)) | pulse[k];
      if (wr && address == 2'd2) m_mask = writedata[W-1:0];
      hist.push_back(in_port);
      if (hist.size() > S + 1) void'(hist.pop_front());
    end
  endtask

  task automatic compare_outputs();
    string nm[3];
    logic [31:0] rd[3];
    logic        iq[3];
    nm = '{"rise", "fall", "any"};
    rd = '{rd_rise, rd_fall, rd_any};
    iq = '{irq_rise, irq_fall, irq_any};
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rd_%s_a%0d", nm[k], address), rd[k], m_read(k, address));
      check($sformatf("irq_%s", nm[k]), 32'(iq[k]), 32'(|(m_ecap[k] & m_mask)));
    end
  endtask

  task automatic tick(input bit do_check = 1'b1);
    if (do_check) begin
      @(negedge clk);
      compare_outputs();
    end
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    idle();
  endtask

  task automatic read_sweep();
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; idle(); address = 2'd0; writedata = '0; in_port = 2'b11;
    tick(1'b0);
    tick(); tick();
    reset = 1'b0;

    // Input held high through reset: no false edge after warm-up.
    repeat (2) read_sweep();

    // Rising bit 0: DATA after 2 clks, capture after 3, irq masked off.
    in_port = 2'b00;
    repeat (4) tick();
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_port = 2'b01; address = 2'd0;
    repeat (3) tick();
    address = 2'd3;
    repeat (2) tick();

    // Mask bit 0 in, new rising edge raises irq; W1C drops it.
    bus_write(2'd2, 32'h1);
    in_port = 2'b00;
    repeat (4) tick();
    bus_write(2'd3, 32'h3);
    in_port = 2'b01; address = 2'd3;
    repeat (5) tick();
    bus_write(2'd3, 32'h1);
    repeat (2) tick();

    // Bit 1 rises then falls; clear bit 1 in the exact cycle the fall is detected.
    in_port = 2'b11;
    repeat (4) tick();
    in_port = 2'b01;
    tick(); tick();
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h2;
    tick();
    idle();
    repeat (2) tick();

    // Writes to read-only / reserved words, oversized mask write.
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    read_sweep();
    bus_write(2'd2, 32'hFFFF_FFFF);
    read_sweep();

    // Mask cleared while capture pending: irq drops, capture kept.
    in_port = 2'b10;
    repeat (4) tick();
    bus_write(2'd2, 32'h0);
    read_sweep();

    // Reset with captures and mask set, and a competing write in the same cycle.
    bus_write(2'd2, 32'h3);
    in_port = 2'b01;
    repeat (4) tick();
    in_port = 2'b10;
    repeat (4) tick();
    reset = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'hFFFF_FFFF;
    tick();
    reset = 1'b0; idle();
    read_sweep();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 249) == 0);
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      tick();
    end
    reset = 1'b0; idle();
    read_sweep();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
